quad2joy: RTL and testbench

- Receive-side counterpart of the joystick-to-quadrature steering generator.
- Decodes a two-phase quadrature stream (steering encoder, or the emulated one) into:
  - a wrapping position count,
  - per-step direction pulses,
  - held left/right levels suitable for joystick-style logic.
- Sits in the clk_6 domain between the steering inputs and any consumer: test/diagnostic overlay, input remapper, or loopback checker.
- Rejects glitches and flags illegal two-bit transitions.

---
 rtl/quad2joy.sv | 198 +++++++++++++++++++
 tb/tb_quad2joy.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad2joy.sv
// ---------------------------------------------------------------------------
// quad2joy
//   Decodes a two-phase quadrature stream (steering encoder or its emulation)
//   into a wrapping position count, one-cycle direction pulses, held
//   left/right joystick-style levels, and an illegal-transition flag/counter.
//
// Ports
//   CLK       in   system clock (clk_6 domain)
//   reset     in   asynchronous active-high reset
//   quad_a    in   phase A, asynchronous
//   quad_b    in   phase B, asynchronous
//   clr       in   synchronous position clear (one cycle)
//   position  out  accumulated step count, two's complement, wraps
//   step_cw   out  one-cycle pulse per accepted clockwise step
//   step_ccw  out  one-cycle pulse per accepted counter-clockwise step
//   dir       out  direction of last valid step, 1 = cw
//   right     out  high while the cw hold timer is nonzero
//   left      out  high while the ccw hold timer is nonzero
//   err       out  one-cycle pulse on an illegal (two-bit) transition
//   err_cnt   out  saturating count of illegal transitions
// ---------------------------------------------------------------------------
module quad2joy #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD        = 22500
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr,
  output logic [CNT_W-1:0] position,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             dir,
  output logic             right,
  output logic             left,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int         TW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
  localparam logic [3:0] FL = 4'(FILTER_LEN);

  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [1:0]                  w_syncOut;
  logic [1:0]                  r_cand;
  logic [3:0]                  r_cnt;
  logic                        w_stable;
  logic [1:0]                  r_acc;
  logic                        r_primed;
  logic                        r_evValid;
  logic [1:0]                  r_evOld;
  logic [1:0]                  r_evNew;
  logic                        w_isCw;
  logic                        w_isCcw;
  logic                        w_isErr;
  logic [CNT_W-1:0]            r_position;
  logic                        r_stepCw;
  logic                        r_stepCcw;
  logic                        r_dir;
  logic                        r_err;
  logic [7:0]                  r_errCnt;
  logic [TW-1:0]               r_cwTimer;
  logic [TW-1:0]               r_ccwTimer;

  // Both phases travel together through the synchronizer chain so the
  // filter always sees a coherent {A,B} pair.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= {quad_a, quad_b};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_syncOut = r_sync[SYNC_STAGES-1];

  // Stability filter: the candidate follows the synchronizer, and the counter
  // measures how long it has been unchanged (saturating at FILTER_LEN).
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cand <= 2'b00;
      r_cnt  <= 4'd0;
    end else if (w_syncOut != r_cand) begin
      r_cand <= w_syncOut;
      r_cnt  <= 4'd1;
    end else if (r_cnt != FL) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign w_stable = (r_cnt == FL);

  // Acceptance: the first stable value after reset only primes the accepted
  // state; later stable changes are handed to the decoder as old/new pairs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_acc     <= 2'b00;
      r_primed  <= 1'b0;
      r_evValid <= 1'b0;
      r_evOld   <= 2'b00;
      r_evNew   <= 2'b00;
    end else begin
      r_evValid <= 1'b0;
      if (w_stable) begin
        if (!r_primed) begin
          r_primed <= 1'b1;
          r_acc    <= r_cand;
        end else if (r_cand != r_acc) begin
          r_acc     <= r_cand;
          r_evValid <= 1'b1;
          r_evOld   <= r_acc;
          r_evNew   <= r_cand;
        end
      end
    end
  end

  // Transition table: single-bit moves along 00-10-11-01 are cw, the reverse
  // walk is ccw, and anything else (both bits flipping) is illegal.
  always_comb begin
    w_isCw  = 1'b0;
    w_isCcw = 1'b0;
    w_isErr = 1'b0;
    if (r_evValid) begin
      case ({r_evOld, r_evNew})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_isCw  = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_isCcw = 1'b1;
        default:                                w_isErr = 1'b1;
      endcase
    end
  end

  // Registered outputs: pulses, position (clear has priority), direction,
  // error counter and the two mutually exclusive hold timers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_position <= '0;
      r_stepCw   <= 1'b0;
      r_stepCcw  <= 1'b0;
      r_dir      <= 1'b0;
      r_err      <= 1'b0;
      r_errCnt   <= 8'd0;
      r_cwTimer  <= '0;
      r_ccwTimer <= '0;
    end else begin
      r_stepCw  <= w_isCw;
      r_stepCcw <= w_isCcw;
      r_err     <= w_isErr;

      if (clr) begin
        r_position <= '0;
      end else if (w_isCw) begin
        r_position <= r_position + CNT_W'(1);
      end else if (w_isCcw) begin
        r_position <= r_position - CNT_W'(1);
      end

      if (w_isCw || w_isCcw) begin
        r_dir <= w_isCw;
      end

      if (w_isErr && (r_errCnt != 8'hFF)) begin
        r_errCnt <= r_errCnt + 8'd1;
      end

      if (w_isCw) begin
        r_cwTimer  <= TW'(HOLD);
        r_ccwTimer <= '0;
      end else if (w_isCcw) begin
        r_ccwTimer <= TW'(HOLD);
        r_cwTimer  <= '0;
      end else begin
        if (r_cwTimer != '0) begin
          r_cwTimer <= r_cwTimer - TW'(1);
        end
        if (r_ccwTimer != '0) begin
          r_ccwTimer <= r_ccwTimer - TW'(1);
        end
      end
    end
  end

  assign position = r_position;
  assign step_cw  = r_stepCw;
  assign step_ccw = r_stepCcw;
  assign dir      = r_dir;
  assign err      = r_err;
  assign err_cnt  = r_errCnt;
  assign right    = (r_cwTimer != '0);
  assign left     = (r_ccwTimer != '0);

endmodule

// File: tb/tb_quad2joy.sv
// ---------------------------------------------------------------------------
// tb_quad2joy
//   Directed and randomized quadrature stimulus for quad2joy, checked against
//   a phase-index reference model (cw = index +1, ccw = index -1, two apart
//   = illegal) with cycle-exact pulse timing and hold-timer expiry.
// ---------------------------------------------------------------------------
module tb_quad2joy;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int CNT_W       = 8;
  localparam int HOLD        = 22500;
  localparam int PULSE_OFS   = SYNC_STAGES + FILTER_LEN + 2;
  localparam int POS_MASK    = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             quad_a = 1'b0;
  logic             quad_b = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] position;
  logic             step_cw;
  logic             step_ccw;
  logic             dir;
  logic             right;
  logic             left;
  logic             err;
  logic [7:0]       err_cnt;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  logic [1:0] mState;
  int         mPos;
  int         mErrCnt;
  bit         mDir;
  int         mLastDir;
  int         mStepCyc;

  quad2joy #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .CNT_W      (CNT_W),
    .HOLD       (HOLD)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
    .clr     (clr),
    .position(position),
    .step_cw (step_cw),
    .step_ccw(step_ccw),
    .dir     (dir),
    .right   (right),
    .left    (left),
    .err     (err),
    .err_cnt (err_cnt)
  );

  // Free-running clock and a posedge counter used as the bench timebase.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Position of an {A,B} pair along the clockwise walk 00,10,11,01.
  function automatic int phaseIdx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] phaseAb(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare every slowly changing output against the model at the current cycle.
  task automatic checkSteady();
    bit expRight;
    bit expLeft;
    expRight = (mLastDir == 1) && ((cyc - mStepCyc) < HOLD);
    expLeft  = (mLastDir == 2) && ((cyc - mStepCyc) < HOLD);
    checkOutput("position", 32'(position), 32'(mPos));
    checkOutput("dir", 32'(dir), 32'(mDir));
    checkOutput("err_cnt", 32'(err_cnt), 32'(mErrCnt));
    checkOutput("right", 32'(right), 32'(expRight));
    checkOutput("left", 32'(left), 32'(expLeft));
  endtask

  // Drive a new {A,B} level for 'hold' cycles, checking the pulses every cycle.
  // Optionally pulse clr so that it lands on the same edge as the step.
  task automatic applyStimulus(input logic [1:0] ab, input int hold, input bit withClr);
    bit accepted;
    int kind;
    int d;
    kind     = 0;
    accepted = (hold >= FILTER_LEN) && (ab != mState);
    if (accepted) begin
      d = (phaseIdx(ab) - phaseIdx(mState) + 4) % 4;
      kind = (d == 1) ? 1 : ((d == 3) ? 2 : 3);
    end
    quad_a = ab[1];
    quad_b = ab[0];
    for (int i = 1; i <= hold; i++) begin
      @(negedge CLK);
      clr = 1'b0;
      if (accepted && (i == PULSE_OFS)) begin
        mState = ab;
        if (kind == 1) begin
          mPos     = (mPos + 1) & POS_MASK;
          mDir     = 1'b1;
          mLastDir = 1;
          mStepCyc = cyc;
        end else if (kind == 2) begin
          mPos     = (mPos - 1) & POS_MASK;
          mDir     = 1'b0;
          mLastDir = 2;
          mStepCyc = cyc;
        end else begin
          mErrCnt = (mErrCnt < 255) ? mErrCnt + 1 : 255;
        end
        if (withClr) mPos = 0;
      end
      checkOutput("step_cw", 32'(step_cw), 32'(accepted && (i == PULSE_OFS) && (kind == 1)));
      checkOutput("step_ccw", 32'(step_ccw), 32'(accepted && (i == PULSE_OFS) && (kind == 2)));
      checkOutput("err", 32'(err), 32'(accepted && (i == PULSE_OFS) && (kind == 3)));
      if (withClr && (i == PULSE_OFS - 1)) clr = 1'b1;
    end
    checkSteady();
  endtask

  // Assert reset with a given input level, confirm the outputs clear at once,
  // then release and let the decoder prime without producing any event.
  task automatic applyReset(input logic [1:0] ab);
    @(negedge CLK);
    quad_a = ab[1];
    quad_b = ab[0];
    reset  = 1'b1;
    #1;
    checkOutput("rst_position", 32'(position), 32'd0);
    checkOutput("rst_step_cw", 32'(step_cw), 32'd0);
    checkOutput("rst_step_ccw", 32'(step_ccw), 32'd0);
    checkOutput("rst_dir", 32'(dir), 32'd0);
    checkOutput("rst_right", 32'(right), 32'd0);
    checkOutput("rst_left", 32'(left), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    mPos     = 0;
    mErrCnt  = 0;
    mDir     = 1'b0;
    mLastDir = 0;
    mStepCyc = 0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      checkOutput("prime_step_cw", 32'(step_cw), 32'd0);
      checkOutput("prime_step_ccw", 32'(step_ccw), 32'd0);
      checkOutput("prime_err", 32'(err), 32'd0);
    end
    mState = ab;
    checkSteady();
  endtask

  // Run forward to the last cycle the active hold level should still be high,
  // then confirm it drops exactly one cycle later.
  task automatic checkHoldExpiry(input bit isRight);
    int target;
    target = mStepCyc + HOLD - 1;
    while (cyc < target) @(negedge CLK);
    checkOutput(isRight ? "right_last" : "left_last", 32'(isRight ? right : left), 32'd1);
    @(negedge CLK);
    checkOutput(isRight ? "right_expired" : "left_expired", 32'(isRight ? right : left), 32'd0);
    checkSteady();
  endtask

  // Single-cycle position clear while the inputs stay still.
  task automatic clearPosition();
    clr = 1'b1;
    @(negedge CLK);
    clr  = 1'b0;
    mPos = 0;
    checkOutput("clr_position", 32'(position), 32'd0);
  endtask

  // Directed scenarios followed by a randomized mix of steps, glitches,
  // illegal jumps and clears, ending with a reset while the inputs sit at 11.
  initial begin
    int op;
    int idx;
    applyReset(2'b00);

    applyStimulus(2'b10, 10, 1'b0);
    applyStimulus(2'b11, 10, 1'b0);
    applyStimulus(2'b01, 10, 1'b0);
    applyStimulus(2'b00, 10, 1'b0);
    checkOutput("cw_seq_position", 32'(position), 32'd4);
    checkOutput("cw_seq_dir", 32'(dir), 32'd1);
    checkOutput("cw_seq_right", 32'(right), 32'd1);

    applyStimulus(2'b01, 10, 1'b0);
    checkOutput("ccw_right_drop", 32'(right), 32'd0);
    applyStimulus(2'b11, 10, 1'b0);
    checkOutput("ccw_seq_position", 32'(position), 32'd2);
    checkOutput("ccw_seq_left", 32'(left), 32'd1);
    checkHoldExpiry(1'b0);

    applyStimulus(2'b01, FILTER_LEN - 1, 1'b0);
    applyStimulus(2'b11, 10, 1'b0);
    checkOutput("glitch_position", 32'(position), 32'd2);

    applyStimulus(2'b01, 10, 1'b0);
    applyStimulus(2'b00, 10, 1'b0);
    applyStimulus(2'b11, 10, 1'b0);
    checkOutput("illegal_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("illegal_position", 32'(position), 32'd4);
    applyStimulus(2'b01, 10, 1'b0);
    checkOutput("after_illegal_position", 32'(position), 32'd5);
    checkHoldExpiry(1'b1);

    clearPosition();
    for (int n = 0; n < 260; n++) begin
      applyStimulus(phaseAb(phaseIdx(mState) + 3), 9, 1'b0);
    end
    checkOutput("wrap_position", 32'(position), 32'hFC);
    applyStimulus(phaseAb(phaseIdx(mState) + 3), 9, 1'b1);
    checkOutput("clr_with_step", 32'(position), 32'd0);

    for (int n = 0; n < 256; n++) begin
      applyStimulus(phaseAb(phaseIdx(mState) + 2), 9, 1'b0);
    end
    checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);

    for (int n = 0; n < 150; n++) begin
      op  = int'($urandom_range(0, 9));
      idx = phaseIdx(mState);
      if (op <= 3) begin
        applyStimulus(phaseAb(idx + 1), int'($urandom_range(9, 14)), 1'b0);
      end else if (op <= 6) begin
        applyStimulus(phaseAb(idx + 3), int'($urandom_range(9, 14)), 1'b0);
      end else if (op == 7) begin
        applyStimulus(phaseAb(idx + int'($urandom_range(1, 3))), int'($urandom_range(1, FILTER_LEN - 1)), 1'b0);
        applyStimulus(mState, 9, 1'b0);
      end else if (op == 8) begin
        applyStimulus(phaseAb(idx + 2), int'($urandom_range(9, 14)), 1'b0);
      end else begin
        applyStimulus(phaseAb(idx + 1), 9, 1'b1);
      end
    end

    applyStimulus(2'b11, 9, 1'b0);
    applyReset(2'b11);
    applyStimulus(2'b01, 10, 1'b0);
    checkOutput("primed11_position", 32'(position), 32'd1);
    checkOutput("primed11_dir", 32'(dir), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
